// File: rtl/graphics_pkg.sv
// Shared types and constants for the pixel compositor: fade states, RGB struct,
// per-player tint colours and a per-channel averaging helper.
package graphics_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        OVER     = 2'd2,
        FADE_IN  = 2'd3
    } comp_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int ACTIVE_H_DEFAULT = 1280;
    localparam int ACTIVE_V_DEFAULT = 720;

    localparam logic [23:0] PLAYER_COLORS [4] = '{
        24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00
    };

    // 50/50 mix per channel; the 9-bit sum keeps the carry before halving
    function automatic rgb_t avg_rgb(input rgb_t a, input rgb_t b);
        rgb_t       res;
        logic [8:0] sum_r;
        logic [8:0] sum_g;
        logic [8:0] sum_b;
        sum_r = {1'b0, a.r} + {1'b0, b.r};
        sum_g = {1'b0, a.g} + {1'b0, b.g};
        sum_b = {1'b0, a.b} + {1'b0, b.b};
        res.r = sum_r[8:1];
        res.g = sum_g[8:1];
        res.b = sum_b[8:1];
        return res;
    endfunction

endpackage

// File: rtl/alpha_blend.sv
// Combinational fade blend of one RGB triple towards OVER_COLOR, weighted by
// alpha out of FADE_FRAMES.
module alpha_blend
    import graphics_pkg::*;
#(
    parameter int          FADE_FRAMES = 16,
    parameter logic [23:0] OVER_COLOR  = 24'h800000
) (
    input  rgb_t                         base_i,
    input  logic [$clog2(FADE_FRAMES):0] alpha_i,
    output rgb_t                         blend_o
);

    localparam int   FL       = $clog2(FADE_FRAMES);
    localparam int   PW       = 9 + FL;
    localparam rgb_t OVER_RGB = rgb_t'(OVER_COLOR);

    logic [PW-1:0] alpha_s;
    logic [PW-1:0] inv_s;

    assign alpha_s = PW'(alpha_i);
    assign inv_s   = PW'(FADE_FRAMES) - alpha_s;

    // Weights sum to FADE_FRAMES, so the sum never exceeds 255*FADE_FRAMES
    function automatic logic [7:0] mix(input logic [7:0] b, input logic [7:0] o,
                                       input logic [PW-1:0] w_b, input logic [PW-1:0] w_o);
        logic [PW-1:0] sum;
        sum = PW'(b) * w_b + PW'(o) * w_o;
        return sum[FL+7:FL];
    endfunction

    assign blend_o.r = mix(base_i.r, OVER_RGB.r, inv_s, alpha_s);
    assign blend_o.g = mix(base_i.g, OVER_RGB.g, inv_s, alpha_s);
    assign blend_o.b = mix(base_i.b, OVER_RGB.b, inv_s, alpha_s);

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage pixel compositor: layer priority, collision flash and game-over fade.
// Optional build macro PLAYER_TINT_EN blends owned video pixels with the player colour.
module pixel_compositor
    import graphics_pkg::*;
#(
    parameter int          ACTIVE_H_PIXELS = ACTIVE_H_DEFAULT,
    parameter int          ACTIVE_LINES    = ACTIVE_V_DEFAULT,
    parameter int          NUM_PLAYERS     = 2,
    parameter logic [23:0] COLLISION_COLOR = 24'h800000,
    parameter logic [23:0] WALL_COLOR      = 24'hFF0080,
    parameter logic [23:0] OVER_COLOR      = 24'h800000,
    parameter int          FLASH_FRAMES    = 8,
    parameter int          FADE_FRAMES     = 16,
    localparam int         PLAYER_W        = $clog2(NUM_PLAYERS + 1)
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic [10:0]         hcount_in,
    input  logic [9:0]          vcount_in,
    input  logic [PLAYER_W-1:0] pixel_player_num,
    input  logic                is_wall,
    input  logic                is_collision,
    input  logic [23:0]         pixel_in,
    input  logic                ui_valid,
    input  logic [23:0]         ui_pixel,
    input  logic [2:0]          game_state_in,
    output logic [10:0]         hcount_out,
    output logic [9:0]          vcount_out,
    output logic [23:0]         pixel_out,
    output logic                collision_frame
);

    localparam int             AW         = $clog2(FADE_FRAMES) + 1;
    localparam int             FW         = $clog2(FLASH_FRAMES);
    localparam logic [10:0]    H_LIM      = 11'(ACTIVE_H_PIXELS);
    localparam logic [9:0]     V_LIM      = 10'(ACTIVE_LINES);
    localparam logic [AW-1:0]  ALPHA_MAX  = AW'(FADE_FRAMES);
    localparam logic [FW-1:0]  FLASH_LOAD = FW'(FLASH_FRAMES - 1);

    comp_state_t   state_q, state_d;
    logic [AW-1:0] alpha_q, alpha_d;
    logic [FW-1:0] flash_q, flash_d;
    logic          coll_seen_q, coll_seen_d;
    logic          cf_q, cf_d;

    logic [10:0]   h0_q;
    logic [9:0]    v0_q;
    rgb_t          base0_q;
    logic          act0_q;
    logic [AW-1:0] alpha0_q;

    logic [10:0]   hout_q;
    logic [9:0]    vout_q;
    logic [23:0]   pix_q;

    logic active_s, frame_tick_s, playing_s, coll_hit_s, flash_show_s;
    rgb_t video_s, base_s, blend_s;

    assign active_s     = (hcount_in < H_LIM) && (vcount_in < V_LIM);
    assign frame_tick_s = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    assign playing_s    = (game_state_in != 3'd0);
    assign coll_hit_s   = active_s && is_collision;
    // Odd flash counts make collision pixels transparent
    assign flash_show_s = (flash_q == FW'(0)) || !flash_q[0];

`ifdef PLAYER_TINT_EN
    logic [1:0] tint_idx_s;
    assign tint_idx_s = 2'(pixel_player_num - PLAYER_W'(1));
    assign video_s    = (pixel_player_num != PLAYER_W'(0)) ?
                        avg_rgb(rgb_t'(pixel_in), rgb_t'(PLAYER_COLORS[tint_idx_s])) :
                        rgb_t'(pixel_in);
`else
    logic unused_player_s;
    assign unused_player_s = ^pixel_player_num;
    assign video_s         = rgb_t'(pixel_in);
`endif

    // Fade FSM: entering FADE_OUT already counts the first fade step
    always_comb begin
        state_d = state_q;
        alpha_d = alpha_q;
        if (frame_tick_s) begin
            case (state_q)
                PLAY: begin
                    if (!playing_s) begin
                        state_d = FADE_OUT;
                        alpha_d = AW'(1);
                    end else begin
                        state_d = PLAY;
                    end
                end
                FADE_OUT: begin
                    if (playing_s) begin
                        state_d = FADE_IN;
                    end else begin
                        alpha_d = alpha_q + AW'(1);
                        state_d = (alpha_q + AW'(1) == ALPHA_MAX) ? OVER : FADE_OUT;
                    end
                end
                OVER: begin
                    state_d = playing_s ? FADE_IN : OVER;
                end
                FADE_IN: begin
                    if (!playing_s) begin
                        state_d = FADE_OUT;
                    end else begin
                        alpha_d = alpha_q - AW'(1);
                        state_d = (alpha_q == AW'(1)) ? PLAY : FADE_IN;
                    end
                end
                default: begin
                    state_d = PLAY;
                    alpha_d = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Collision bookkeeping per frame
    always_comb begin
        coll_seen_d = coll_seen_q;
        cf_d        = 1'b0;
        flash_d     = flash_q;
        if (frame_tick_s) begin
            coll_seen_d = coll_hit_s;
            cf_d        = coll_seen_q;
            if (coll_seen_q) begin
                flash_d = FLASH_LOAD;
            end else if (flash_q != FW'(0)) begin
                flash_d = flash_q - FW'(1);
            end else begin
                flash_d = flash_q;
            end
        end else begin
            coll_seen_d = coll_seen_q || coll_hit_s;
        end
    end

    // Stage 0 layer priority
    always_comb begin
        base_s = video_s;
        if (state_q == OVER) begin
            base_s = rgb_t'(OVER_COLOR);
        end else if (ui_valid) begin
            base_s = rgb_t'(ui_pixel);
        end else if (is_collision && flash_show_s) begin
            base_s = rgb_t'(COLLISION_COLOR);
        end else if (is_wall) begin
            base_s = rgb_t'(WALL_COLOR);
        end else begin
            base_s = video_s;
        end
    end

    alpha_blend #(
        .FADE_FRAMES(FADE_FRAMES),
        .OVER_COLOR (OVER_COLOR)
    ) u_blend (
        .base_i (base0_q),
        .alpha_i(alpha0_q),
        .blend_o(blend_s)
    );

    // Control state and both pipeline stages
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= PLAY;
            alpha_q     <= '0;
            flash_q     <= '0;
            coll_seen_q <= 1'b0;
            cf_q        <= 1'b0;
            h0_q        <= '0;
            v0_q        <= '0;
            base0_q     <= '0;
            act0_q      <= 1'b0;
            alpha0_q    <= '0;
            hout_q      <= '0;
            vout_q      <= '0;
            pix_q       <= '0;
        end else begin
            state_q     <= state_d;
            alpha_q     <= alpha_d;
            flash_q     <= flash_d;
            coll_seen_q <= coll_seen_d;
            cf_q        <= cf_d;
            h0_q        <= hcount_in;
            v0_q        <= vcount_in;
            base0_q     <= base_s;
            act0_q      <= active_s;
            alpha0_q    <= alpha_q;
            hout_q      <= h0_q;
            vout_q      <= v0_q;
            pix_q       <= act0_q ? blend_s : 24'h000000;
        end
    end

    assign hcount_out      = hout_q;
    assign vcount_out      = vout_q;
    assign pixel_out       = pix_q;
    assign collision_frame = cf_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed self-checking bench for pixel_compositor; frames are advanced by a
// single (0,0) pixel so fades and flashes run in a few cycles each.
module tb_pixel_compositor;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [10:0] hcount_in;
    logic [9:0]  vcount_in;
    logic [1:0]  pixel_player_num;
    logic        is_wall, is_collision, ui_valid;
    logic [23:0] pixel_in, ui_pixel;
    logic [2:0]  game_state_in;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic [23:0] pixel_out;
    logic        collision_frame;

    int tests = 0;
    int fails = 0;
    logic cf;

    always #5 clk_in = ~clk_in;

    pixel_compositor dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .pixel_player_num(pixel_player_num),
        .is_wall         (is_wall),
        .is_collision    (is_collision),
        .pixel_in        (pixel_in),
        .ui_valid        (ui_valid),
        .ui_pixel        (ui_pixel),
        .game_state_in   (game_state_in),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .pixel_out       (pixel_out),
        .collision_frame (collision_frame)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [10:0] h, input logic [9:0] v, input logic [1:0] ply,
                         input logic wall, input logic coll, input logic [23:0] pix,
                         input logic uiv, input logic [23:0] ui);
        hcount_in        = h;
        vcount_in        = v;
        pixel_player_num = ply;
        is_wall          = wall;
        is_collision     = coll;
        pixel_in         = pix;
        ui_valid         = uiv;
        ui_pixel         = ui;
    endtask

    task automatic idle();
        drive(11'd1300, 10'd5, 2'd0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000);
    endtask

    task automatic pix_chk(input string tag, input logic [10:0] h, input logic [9:0] v,
                           input logic [1:0] ply, input logic wall, input logic coll,
                           input logic [23:0] pix, input logic uiv, input logic [23:0] ui,
                           input logic [23:0] exp);
        drive(h, v, ply, wall, coll, pix, uiv, ui);
        @(posedge clk_in); #1;
        idle();
        @(posedge clk_in); #1;
        chk(tag, {40'd0, pixel_out}, {40'd0, exp});
    endtask

    task automatic new_frame(output logic cf_o);
        drive(11'd0, 10'd0, 2'd0, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000);
        @(posedge clk_in); #1;
        cf_o = collision_frame;
        idle();
    endtask

    initial begin
        // 1. reset with random inputs, then latency
        rst_in        = 1'b1;
        game_state_in = 3'd1;
        for (int i = 0; i < 3; i++) begin
            drive(11'($urandom), 10'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  24'($urandom), 1'($urandom), 24'($urandom));
            @(posedge clk_in); #1;
            chk("reset_outs", {18'd0, pixel_out, hcount_out, vcount_out, collision_frame},
                64'd0);
        end
        rst_in = 1'b0;
        drive(11'd10, 10'd20, 2'd0, 1'b0, 1'b0, 24'h123456, 1'b0, 24'h000000);
        @(posedge clk_in); #1;
        chk("latency_1cyc", {29'd0, pixel_out, hcount_out}, 64'd0);
        idle();
        @(posedge clk_in); #1;
        chk("latency_2cyc", {19'd0, pixel_out, hcount_out, vcount_out},
            {19'd0, 24'h123456, 11'd10, 10'd20});

        // 2. layer priority and active-area boundaries
        pix_chk("prio_ui",   11'd10, 10'd10, 2'd0, 1'b1, 1'b1, 24'h111111, 1'b1, 24'hABCDEF, 24'hABCDEF);
        pix_chk("prio_coll", 11'd10, 10'd10, 2'd0, 1'b1, 1'b1, 24'h111111, 1'b0, 24'h000000, 24'h800000);
        pix_chk("prio_wall", 11'd10, 10'd10, 2'd0, 1'b1, 1'b0, 24'h111111, 1'b0, 24'h000000, 24'hFF0080);
        pix_chk("prio_video", 11'd10, 10'd10, 2'd0, 1'b0, 1'b0, 24'h345678, 1'b0, 24'h000000, 24'h345678);
        pix_chk("oob_h",     11'd1280, 10'd10, 2'd0, 1'b1, 1'b0, 24'h345678, 1'b1, 24'hABCDEF, 24'h000000);
        pix_chk("oob_v",     11'd10, 10'd720, 2'd0, 1'b0, 1'b0, 24'h345678, 1'b0, 24'h000000, 24'h000000);
        pix_chk("edge_in",   11'd1279, 10'd719, 2'd0, 1'b0, 1'b0, 24'h0A0B0C, 1'b0, 24'h000000, 24'h0A0B0C);

        // 3. collision pulse and flash (flash 7 after load)
        new_frame(cf);
        chk("cf_pulse", {63'd0, cf}, 64'd1);
        @(posedge clk_in); #1;
        chk("cf_one_cycle", {63'd0, collision_frame}, 64'd0);
        pix_chk("flash7_transp", 11'd50, 10'd50, 2'd0, 1'b0, 1'b1, 24'h112233, 1'b0, 24'h000000, 24'h112233);
        new_frame(cf);
        chk("cf_reload", {63'd0, cf}, 64'd1);
        new_frame(cf);
        chk("cf_quiet", {63'd0, cf}, 64'd0);
        pix_chk("flash6_solid", 11'd50, 10'd50, 2'd0, 1'b0, 1'b1, 24'h112233, 1'b0, 24'h000000, 24'h800000);
        new_frame(cf);
        new_frame(cf);
        new_frame(cf);
        pix_chk("flash5_to_wall", 11'd50, 10'd50, 2'd0, 1'b1, 1'b1, 24'h112233, 1'b0, 24'h000000, 24'hFF0080);
        new_frame(cf);
        for (int i = 0; i < 8; i++) begin
            new_frame(cf);
            chk("cf_low_countdown", {63'd0, cf}, 64'd0);
        end
        pix_chk("flash0_solid", 11'd50, 10'd50, 2'd0, 1'b0, 1'b1, 24'h112233, 1'b0, 24'h000000, 24'h800000);
        new_frame(cf);

        // 4. fade out over 16 frames, then OVER
        game_state_in = 3'd0;
        for (int i = 1; i <= 16; i++) begin
            new_frame(cf);
            if (i == 1)
                pix_chk("fade_a1", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hF7EFEF);
            if (i == 8)
                pix_chk("fade_a8", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hBF7F7F);
            if (i == 15)
                pix_chk("fade_a15", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'h870F0F);
        end
        pix_chk("over_ui_supp", 11'd100, 10'd100, 2'd0, 1'b1, 1'b0, 24'hFFFFFF, 1'b1, 24'h00FF00, 24'h800000);
        new_frame(cf);
        pix_chk("over_stays",   11'd200, 10'd300, 2'd0, 1'b0, 1'b0, 24'h123456, 1'b0, 24'h000000, 24'h800000);
        pix_chk("over_oob",     11'd1500, 10'd300, 2'd0, 1'b0, 1'b0, 24'h123456, 1'b0, 24'h000000, 24'h000000);

        // 5. fade back in, reversal at alpha 5, reset at alpha 10
        game_state_in = 3'd2;
        new_frame(cf);
        pix_chk("fadein_a16", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'h800000);
        for (int i = 0; i < 16; i++) new_frame(cf);
        pix_chk("back_play", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hFFFFFF);
        game_state_in = 3'd0;
        for (int i = 0; i < 5; i++) new_frame(cf);
        pix_chk("out_a5", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hD7AFAF);
        game_state_in = 3'd1;
        new_frame(cf);
        pix_chk("rev_keeps_a5", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hD7AFAF);
        new_frame(cf);
        pix_chk("in_a4", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hDFBFBF);
        for (int i = 0; i < 4; i++) new_frame(cf);
        pix_chk("in_a0", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hFFFFFF);
        game_state_in = 3'd0;
        new_frame(cf);
        pix_chk("play_restart_a1", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hF7EFEF);
        for (int i = 0; i < 9; i++) new_frame(cf);
        pix_chk("out_a10", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hAF5F5F);
        game_state_in = 3'd1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        chk("midfade_reset", {40'd0, pixel_out}, 64'd0);
        pix_chk("after_reset_play", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hFFFFFF);
        new_frame(cf);
        chk("after_reset_no_cf", {63'd0, cf}, 64'd0);
        pix_chk("after_reset_stay", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hFFFFFF);

        // 6. player tint
`ifdef PLAYER_TINT_EN
        pix_chk("tint_p1_black", 11'd60, 10'd60, 2'd1, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 24'h7F0000);
        pix_chk("tint_p2",       11'd60, 10'd60, 2'd2, 1'b0, 1'b0, 24'h805070, 1'b0, 24'h000000, 24'h40A738);
`else
        pix_chk("tint_p1_black", 11'd60, 10'd60, 2'd1, 1'b0, 1'b0, 24'h000000, 1'b0, 24'h000000, 24'h000000);
        pix_chk("tint_p2",       11'd60, 10'd60, 2'd2, 1'b0, 1'b0, 24'h805070, 1'b0, 24'h000000, 24'h805070);
`endif
        pix_chk("tint_p0",       11'd60, 10'd60, 2'd0, 1'b0, 1'b0, 24'h805070, 1'b0, 24'h000000, 24'h805070);
        pix_chk("tint_wall",     11'd60, 10'd60, 2'd1, 1'b1, 1'b0, 24'h805070, 1'b0, 24'h000000, 24'hFF0080);

        // alpha was 0 after reset: game over must step straight to alpha 1
        game_state_in = 3'd0;
        new_frame(cf);
        pix_chk("reset_alpha0", 11'd100, 10'd100, 2'd0, 1'b0, 1'b0, 24'hFFFFFF, 1'b0, 24'h000000, 24'hF7EFEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
